// File: rtl/pix_tx.sv
// pix_tx: parallel pixel-bus frame generator (pix_fv/pix_lv/pix_d) with built-in test patterns
// or a ready/trigger word stream as the pixel source.
module pix_tx #(
    parameter int ImageWidthMax  = 256,
    parameter int ImageHeightMax = 256,
    parameter int HBlank         = 8,
    parameter int VBlank         = 16,
    parameter int FvLead         = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_start,
    input  logic [$clog2(ImageWidthMax + 1)-1:0]  cmd_width,
    input  logic [$clog2(ImageHeightMax + 1)-1:0] cmd_height,
    input  logic [1:0]                            cmd_pattern,
    input  logic [11:0]                           cmd_const,
    input  logic                                  stream_ready,
    output logic                                  stream_trigger,
    input  logic [15:0]                           stream_data,
    output logic [11:0]                           pix_d,
    output logic                                  pix_fv,
    output logic                                  pix_lv,
    output logic                                  status_busy,
    output logic                                  status_done,
    output logic                                  status_underflow
);
    localparam int WW   = $clog2(ImageWidthMax + 1);
    localparam int HW   = $clog2(ImageHeightMax + 1);
    localparam int BMAX = VBlank > HBlank ? VBlank : HBlank;
    localparam int CMAX = BMAX > FvLead ? BMAX : FvLead;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLANK, TRAIL, VBLANK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [WW-1:0] x, w;
    logic [HW-1:0] y, h;
    logic [1:0]    pat;
    logic [11:0]   cst, pix_val;
    logic          accept, line_end, last_y, unused;

    assign accept         = cmd_start && cmd_width != '0 && cmd_height != '0;
    assign line_end       = x == w - WW'(1);
    assign last_y         = y == h - HW'(1);
    assign stream_trigger = state == LINE && pat == 2'd3 && stream_ready;
    assign unused         = ^stream_data[15:12];

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? LEAD : IDLE;
            LEAD:    state_n = cnt == CW'(FvLead - 1) ? LINE : LEAD;
            LINE:    state_n = !line_end ? LINE : last_y ? TRAIL : HBLANK;
            HBLANK:  state_n = cnt == CW'(HBlank - 1) ? LINE : HBLANK;
            TRAIL:   state_n = cnt == CW'(FvLead - 1) ? VBLANK : TRAIL;
            VBLANK:  state_n = cnt == CW'(VBlank - 1) ? IDLE : VBLANK;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        pix_val = pat == 2'd0 ? 12'(x) + 12'(y) :
                  pat == 2'd1 ? {y[5:0], x[5:0]} :
                  pat == 2'd2 ? cst :
                  stream_ready ? stream_data[11:0] : 12'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Outputs are the registered image of the current state, so every pixel-bus
    // signal (including stream data captured on trigger) shares the same one-cycle lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= '0;
            x                <= '0;
            y                <= '0;
            w                <= '0;
            h                <= '0;
            pat              <= '0;
            cst              <= '0;
            pix_d            <= '0;
            pix_fv           <= 1'b0;
            pix_lv           <= 1'b0;
            status_busy      <= 1'b0;
            status_done      <= 1'b0;
            status_underflow <= 1'b0;
        end else begin
            cnt         <= state_n != state ? '0 : cnt + CW'(1);
            x           <= state == LINE && !line_end ? x + WW'(1) : '0;
            y           <= state == IDLE ? '0 : state == LINE && line_end && !last_y ? y + HW'(1) : y;
            pix_d       <= state == LINE ? pix_val : 12'd0;
            pix_fv      <= state != IDLE && state != VBLANK;
            pix_lv      <= state == LINE;
            status_busy <= state != IDLE;
            status_done <= state == IDLE && status_busy;
            if (state == IDLE && accept) begin
                w                <= cmd_width;
                h                <= cmd_height;
                pat              <= cmd_pattern;
                cst              <= cmd_const;
                status_underflow <= 1'b0;
            end else if (state == LINE && pat == 2'd3 && !stream_ready) begin
                status_underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pix_tx.sv
// tb_pix_tx: frame-timeline reference model checked every cycle, plus directed literal checks.
module tb_pix_tx;
    localparam int WMAX = 256, HMAX = 256, HB = 8, VB = 16, FL = 2;

    logic        clk = 0, rst = 1, cmd_start = 0;
    logic [8:0]  cmd_width = 0, cmd_height = 0;
    logic [1:0]  cmd_pattern = 0;
    logic [11:0] cmd_const = 0;
    logic        stream_ready = 0, stream_trigger;
    logic [15:0] stream_data = 0;
    logic [11:0] pix_d;
    logic        pix_fv, pix_lv, status_busy, status_done, status_underflow;

    pix_tx #(.ImageWidthMax(WMAX), .ImageHeightMax(HMAX), .HBlank(HB), .VBlank(VB), .FvLead(FL)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_width(cmd_width), .cmd_height(cmd_height),
        .cmd_pattern(cmd_pattern), .cmd_const(cmd_const), .stream_ready(stream_ready),
        .stream_trigger(stream_trigger), .stream_data(stream_data), .pix_d(pix_d), .pix_fv(pix_fv),
        .pix_lv(pix_lv), .status_busy(status_busy), .status_done(status_done),
        .status_underflow(status_underflow)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    // model: m_n = state-timeline index of the current frame (outputs show index m_n-1)
    bit m_act = 0, m_done = 0, m_uf = 0, chk = 0;
    int m_n = 0, m_t = 0, m_w = 0, m_h = 0, m_pat = 0, m_cst = 0, m_d = 0;

    function automatic void ph(input int p, output bit fv, output bit lv, output int x, output int y);
        int q, act;
        fv = 0; lv = 0; x = 0; y = 0;
        if (!m_act || p < 0 || p >= m_t) return;
        q = p;
        act = m_h * m_w + (m_h - 1) * HB;
        if (q < FL) begin fv = 1; return; end
        q -= FL;
        if (q < act) begin
            fv = 1;
            y = q / (m_w + HB);
            x = q % (m_w + HB);
            lv = x < m_w;
            if (!lv) x = 0;
            return;
        end
        q -= act;
        fv = q < FL;
    endfunction

    function automatic int pixval(input int x, input int y, input bit rdy, input int data);
        case (m_pat)
            0:       return (x + y) % 4096;
            1:       return ((y % 64) << 6) | (x % 64);
            2:       return m_cst;
            default: return rdy ? (data & 12'hfff) : 0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit lf, ll, pre_idle;
        int lx, ly;
        ph(m_n, lf, ll, lx, ly);
        pre_idle = !m_act || m_n >= m_t;
        if (rst) begin
            m_act = 0; m_uf = 0; m_done = 0; m_d = 0; chk = 1;
        end else begin
            m_done = m_act && m_n == m_t;
            m_d = ll ? pixval(lx, ly, stream_ready, int'(stream_data)) : 0;
            if (ll && m_pat == 3 && !stream_ready) m_uf = 1;
            if (pre_idle && cmd_start && cmd_width != 0 && cmd_height != 0) begin
                m_w = int'(cmd_width); m_h = int'(cmd_height);
                m_pat = int'(cmd_pattern); m_cst = int'(cmd_const);
                m_t = 2 * FL + m_h * m_w + (m_h - 1) * HB + VB;
                m_n = 0; m_act = 1; m_uf = 0;
            end else if (m_act && m_n <= m_t) m_n++;
        end
    end

    always @(negedge clk) begin : cmp
        bit efv, elv, sf, sl, ebusy, etrig;
        int x_unused, y_unused, sx, sy;
        #1;
        if (chk) begin
            ph(m_n - 1, efv, elv, x_unused, y_unused);
            ph(m_n, sf, sl, sx, sy);
            ebusy = m_act && m_n >= 1 && m_n - 1 < m_t;
            etrig = sl && m_pat == 3 && stream_ready;
            tests++;
            if ({pix_fv, pix_lv, status_busy, status_done, status_underflow, stream_trigger} !==
                {efv, elv, ebusy, m_done, m_uf, etrig} || pix_d !== 12'(m_d) || (pix_lv && !pix_fv)) begin
                fails++;
                $display("FAIL cycle-cmp t=%0t: got fv%b lv%b busy%b done%b uf%b trig%b d=%h, want fv%b lv%b busy%b done%b uf%b trig%b d=%h",
                         $time, pix_fv, pix_lv, status_busy, status_done, status_underflow, stream_trigger, pix_d,
                         efv, elv, ebusy, m_done, m_uf, etrig, 12'(m_d));
            end
        end
    end

    // stream source: 0 = random, 1 = fixed word list always ready, 2 = list with ready low on pixel x==1
    int smode = 0, sidx = 0, sbase = 0;
    logic [15:0] src [8];
    always @(posedge clk) if (stream_trigger) sidx <= sidx + 1;
    always @(negedge clk) begin : sdrv
        bit f, l;
        int x, y_unused;
        ph(m_n, f, l, x, y_unused);
        if (smode == 0) begin
            stream_ready = $urandom_range(0, 7) != 0;
            stream_data  = 16'($urandom);
        end else begin
            stream_ready = smode == 1 || !(l && x == 1);
            stream_data  = src[(sidx - sbase) & 7];
        end
    end

    int cyc = 0, fvc, lvc, donec, fall, dcyc;
    bit cap = 0, prev_fv = 0;
    int dq[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cap) begin
        fvc += int'(pix_fv);
        lvc += int'(pix_lv);
        if (pix_lv) dq.push_back(int'(pix_d));
        if (prev_fv && !pix_fv) fall = cyc;
        if (status_done) begin donec++; dcyc = cyc; end
        prev_fv = pix_fv;
    end

    task automatic check(input string nm, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic start_cmd(input int w, input int h, input int p, input int c);
        @(negedge clk);
        cmd_width = 9'(w); cmd_height = 9'(h); cmd_pattern = 2'(p); cmd_const = c[11:0];
        cmd_start = 1;
        sbase = sidx; fvc = 0; lvc = 0; donec = 0; fall = 0; dcyc = 0; prev_fv = 0; dq.delete(); cap = 1;
        @(negedge clk);
        cmd_start = 0; cmd_width = 9'($urandom); cmd_pattern = 2'($urandom); cmd_const = 12'($urandom);
    endtask

    task automatic run_frame(input int w, input int h, input int p, input int c, input int poke);
        start_cmd(w, h, p, c);
        for (int k = 0; k < 20000 && !status_done; k++) begin
            @(negedge clk);
            if (poke != 0 && k == poke) begin
                cmd_start = 1; cmd_width = 2; cmd_height = 1;
            end else cmd_start = 0;
        end
        cmd_start = 0;
        check("frame_done", int'(status_done), 1);
        repeat (2) @(negedge clk);
        cap = 0;
    endtask

    initial begin
        src = '{16'h0ABC, 16'h1123, 16'h0456, 16'h0789, 16'h0DEF, 16'h0111, 16'h0222, 16'h0333};
        repeat (3) @(negedge clk);
        rst = 0;
        check("reset_busy", int'(status_busy), 0);
        smode = 1;
        run_frame(4, 3, 0, 0, 0);
        check("fv_len", fvc, 32);
        check("lv_len", lvc, 12);
        for (int k = 0; k < 4; k++) check($sformatf("first_line_d%0d", k), dq[k], k);
        for (int k = 0; k < 4; k++) check($sformatf("last_line_d%0d", k), dq[8 + k], k + 2);
        check("done_gap", dcyc - fall, 16);
        check("done_cnt", donec, 1);

        run_frame(2, 1, 3, 0, 0);
        check("stream_d0", dq[0], 'hABC);
        check("stream_d1", dq[1], 'h123);
        check("stream_uf", int'(status_underflow), 0);

        smode = 2;
        run_frame(4, 1, 3, 0, 0);
        check("uf_len", lvc, 4);
        check("uf_d0", dq[0], 'hABC);
        check("uf_d1", dq[1], 0);
        check("uf_d2", dq[2], 'h123);
        check("uf_flag", int'(status_underflow), 1);
        repeat (10) @(negedge clk);
        check("uf_sticky", int'(status_underflow), 1);

        smode = 0;
        run_frame(4, 3, 0, 0, 20);
        check("poke_fv_len", fvc, 32);
        check("poke_done_cnt", donec, 1);
        check("uf_cleared", int'(status_underflow), 0);
        @(negedge clk);
        cmd_width = 0; cmd_height = 3; cmd_start = 1;
        @(negedge clk);
        cmd_start = 0;
        repeat (5) @(negedge clk);
        check("w0_ignored", int'(status_busy), 0);

        start_cmd(4, 3, 0, 0);
        repeat (15) @(negedge clk);
        check("in_line2", int'(pix_lv), 1);
        rst = 1; cmd_start = 1; cmd_width = 4; cmd_height = 3;
        @(negedge clk);
        rst = 0; cmd_start = 0;
        #1 check("rst_outputs", int'({pix_fv, pix_lv, status_busy, status_done, status_underflow, stream_trigger, pix_d}), 0);
        cap = 0;
        run_frame(4, 3, 0, 0, 0);
        check("post_rst_fv", fvc, 32);
        check("post_rst_d5", dq[5], 2);

        run_frame(256, 1, 1, 0, 0);
        check("wide_lv", lvc, 256);
        check("wide_fv", fvc, 260);
        check("wide_d65", dq[65], 1);
        check("wide_d255", dq[255], 63);

        for (int i = 0; i < 30; i++)
            run_frame($urandom_range(1, 8), $urandom_range(1, 5), $urandom_range(0, 3), int'($urandom),
                      $urandom_range(0, 3) == 0 ? $urandom_range(1, 19) : 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
